// File: rtl/uart_byte_rx.sv
// 8N1 RS-232 byte receiver: 16x oversampling per bit, 2-of-3 majority vote on samples 6..8,
// one-cycle Rx_Done / frame_err strobes when the stop bit is decided.
module uart_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] baud_set,
    input  logic       Rs232_Rx,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       frame_err,
    output logic       uart_state
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   rx_sync, rx_prev, start_det;
    logic [2:0]             baud_reg;
    logic [8:0]             div_tc, div_cnt;
    logic [3:0]             sample_cnt;
    logic                   tick, decide, bit_end;
    logic                   samp6, samp7, voted;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_reg;
    logic                   done_nxt, err_nxt;

    assign rx_sync    = sync_ff[SYNC_STAGES-1];
    assign start_det  = (state == IDLE) && rx_prev && !rx_sync;
    assign tick       = (state != IDLE) && (div_cnt == div_tc);
    assign decide     = tick && (sample_cnt == 4'd8);
    assign bit_end    = tick && (sample_cnt == 4'd15);
    assign voted      = (samp6 & samp7) | (samp6 & rx_sync) | (samp7 & rx_sync);
    assign uart_state = (state != IDLE);

    // Line synchroniser and edge history reset to idle-high so reset never looks like a start edge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_ff <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], Rs232_Rx};
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        case (baud_reg)
            3'd1:    div_tc = 9'd162;
            3'd2:    div_tc = 9'd80;
            3'd3:    div_tc = 9'd53;
            3'd4:    div_tc = 9'd26;
            default: div_tc = 9'd324;
        endcase
    end

    // Baud select is frozen at start detection; divider and sample counter idle at zero
    always_ff @(posedge Clk) begin
        if (Rst) begin
            baud_reg   <= 3'd0;
            div_cnt    <= 9'd0;
            sample_cnt <= 4'd0;
        end else begin
            if (start_det)
                baud_reg <= baud_set;
            if (state == IDLE) begin
                div_cnt    <= 9'd0;
                sample_cnt <= 4'd0;
            end else if (tick) begin
                div_cnt    <= 9'd0;
                sample_cnt <= sample_cnt + 4'd1;
            end else begin
                div_cnt <= div_cnt + 9'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            samp6     <= 1'b0;
            samp7     <= 1'b0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            if (tick && sample_cnt == 4'd6)
                samp6 <= rx_sync;
            if (tick && sample_cnt == 4'd7)
                samp7 <= rx_sync;
            if (state != DATA)
                bit_idx <= 3'd0;
            else if (bit_end)
                bit_idx <= bit_idx + 3'd1;
            if (state == DATA && decide)
                shift_reg[bit_idx] <= voted;
        end
    end

    // Stop decision happens mid stop bit so the next start edge can follow with no idle gap
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start_det)
                    state_nxt = START;
            end
            START: begin
                if (decide && voted)
                    state_nxt = IDLE;
                else if (bit_end)
                    state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7)
                    state_nxt = STOP;
            end
            STOP: begin
                if (decide) begin
                    state_nxt = IDLE;
                    done_nxt  = voted;
                    err_nxt   = !voted;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            data_byte <= 8'd0;
            Rx_Done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            Rx_Done   <= done_nxt;
            frame_err <= err_nxt;
            if (done_nxt)
                data_byte <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: serial frames are driven cycle by cycle and a frame-level
// model (expected byte / error queue plus timing windows) is checked every cycle.
module tb_uart_byte_rx;

    localparam int SYNC_STAGES = 2;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [2:0] baud_set;
    logic       Rs232_Rx;
    logic [7:0] data_byte;
    logic       Rx_Done;
    logic       frame_err;
    logic       uart_state;

    typedef struct {
        logic [7:0] data;
        bit         err;
        longint     t0;
        int         bp;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         fails = 0;
    int         done_count = 0;
    int         err_count = 0;
    longint     cyc = 0;
    logic [7:0] model_byte = 8'h00;
    bit         prev_event = 1'b0;

    uart_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .baud_set   (baud_set),
        .Rs232_Rx   (Rs232_Rx),
        .data_byte  (data_byte),
        .Rx_Done    (Rx_Done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int bit_period(input logic [2:0] bs);
        case (bs)
            3'd1:    return 2608;
            3'd2:    return 1296;
            3'd3:    return 864;
            3'd4:    return 432;
            default: return 5200;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Drive one 8N1 frame, one line value per clock; glitch_at inverts the line for that single cycle
    task automatic applyStimulus(input logic [7:0] b, input logic stop_val, input int bp,
                                 input int glitch_at, input bit queue_it);
        logic [9:0] frame;
        exp_t       e;
        frame = {stop_val, b, 1'b0};
        if (queue_it) begin
            e.data = b;
            e.err  = !stop_val;
            e.t0   = cyc;
            e.bp   = bit_period(baud_set);
            exp_q.push_back(e);
        end
        for (int c = 0; c < 10 * bp; c++) begin
            Rs232_Rx = frame[c / bp] ^ (c == glitch_at);
            @(negedge Clk);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge Clk);
            n++;
        end
        checkOutput("frames_drained", exp_q.size(), 0);
    endtask

    // Frame-level model compared shortly after every clock edge
    always @(posedge Clk) begin
        exp_t   e;
        longint lat;
        #1;
        if (Rst) begin
            model_byte = 8'h00;
            prev_event = 1'b0;
            checkOutput("reset_data_byte", data_byte, 8'h00);
            checkOutput("reset_rx_done", Rx_Done, 1'b0);
            checkOutput("reset_frame_err", frame_err, 1'b0);
            checkOutput("reset_uart_state", uart_state, 1'b0);
        end else begin
            if (Rx_Done || frame_err) begin
                checkOutput("single_cycle_pulse", prev_event, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_pulse: got Rx_Done=%0b frame_err=%0b, expected no pulse at cycle %0d",
                             Rx_Done, frame_err, cyc);
                end else begin
                    e   = exp_q.pop_front();
                    lat = cyc - e.t0;
                    checkOutput("pulse_kind", {Rx_Done, frame_err}, e.err ? 2'b01 : 2'b10);
                    checkOutput("latency_window", (lat >= 9 * e.bp) && (lat <= 10 * e.bp), 1'b1);
                    checkOutput("uart_state_drop", uart_state, 1'b0);
                    if (!e.err)
                        model_byte = e.data;
                end
                if (Rx_Done)
                    done_count++;
                if (frame_err)
                    err_count++;
                prev_event = 1'b1;
            end else begin
                prev_event = 1'b0;
                if (exp_q.size() != 0 && (cyc - exp_q[0].t0) >= SYNC_STAGES + 4 &&
                    (cyc - exp_q[0].t0) < 9 * exp_q[0].bp)
                    checkOutput("uart_state_busy", uart_state, 1'b1);
            end
            checkOutput("data_byte_model", data_byte, model_byte);
        end
    end

    initial begin
        Rst      = 1'b1;
        baud_set = 3'd4;
        Rs232_Rx = 1'b1;
        repeat (5) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        checkOutput("t0_data_byte", data_byte, 8'h00);

        $display("[TB] clean frame at 115200");
        applyStimulus(8'h55, 1'b1, 432, -1, 1'b1);
        wait_idle(20000);
        checkOutput("t1_data", data_byte, 8'h55);
        checkOutput("t1_done_count", done_count, 1);
        checkOutput("t1_err_count", err_count, 0);
        repeat (100) @(negedge Clk);

        $display("[TB] back-to-back frames with a slightly fast sender");
        applyStimulus(8'hA3, 1'b1, 431, -1, 1'b1);
        applyStimulus(8'h00, 1'b1, 431, -1, 1'b1);
        applyStimulus(8'hFF, 1'b1, 431, -1, 1'b1);
        wait_idle(20000);
        checkOutput("t2_data", data_byte, 8'hFF);
        checkOutput("t2_done_count", done_count, 4);
        repeat (100) @(negedge Clk);

        $display("[TB] short low pulse rejected as a start bit");
        Rs232_Rx = 1'b0;
        repeat (100) @(negedge Clk);
        checkOutput("t3_busy_during_start", uart_state, 1'b1);
        Rs232_Rx = 1'b1;
        repeat (332) @(negedge Clk);
        checkOutput("t3_back_to_idle", uart_state, 1'b0);
        checkOutput("t3_done_count", done_count, 4);
        checkOutput("t3_err_count", err_count, 0);

        $display("[TB] framing error, break, then recovery at 57600");
        baud_set = 3'd3;
        repeat (10) @(negedge Clk);
        applyStimulus(8'h3C, 1'b0, 864, -1, 1'b1);
        wait_idle(20000);
        checkOutput("t4_err_count", err_count, 1);
        checkOutput("t4_data_kept", data_byte, 8'hFF);
        repeat (20 * 864) @(negedge Clk);
        checkOutput("t4_break_no_frame", uart_state, 1'b0);
        checkOutput("t4_break_done_count", done_count, 4);
        Rs232_Rx = 1'b1;
        repeat (2 * 864) @(negedge Clk);
        applyStimulus(8'h81, 1'b1, 864, -1, 1'b1);
        wait_idle(20000);
        checkOutput("t4_data", data_byte, 8'h81);
        checkOutput("t4_done_count", done_count, 5);

        $display("[TB] one-cycle glitch inside the vote window at 38400");
        baud_set = 3'd2;
        repeat (10) @(negedge Clk);
        applyStimulus(8'h96, 1'b1, 1296, 2 * 1296 + 648, 1'b1);
        wait_idle(20000);
        checkOutput("t5_data", data_byte, 8'h96);
        checkOutput("t5_done_count", done_count, 6);
        repeat (100) @(negedge Clk);

        $display("[TB] reset mid-frame, then a clean frame");
        baud_set = 3'd4;
        repeat (10) @(negedge Clk);
        fork
            applyStimulus(8'hF3, 1'b1, 432, -1, 1'b0);
            begin
                repeat (5 * 432 + 216) @(negedge Clk);
                Rst = 1'b1;
                @(negedge Clk);
                checkOutput("t6_reset_data", data_byte, 8'h00);
                checkOutput("t6_reset_state", uart_state, 1'b0);
                Rst = 1'b0;
            end
        join
        repeat (432) @(negedge Clk);
        checkOutput("t6_abort_no_done", done_count, 6);
        applyStimulus(8'h5A, 1'b1, 432, -1, 1'b1);
        wait_idle(20000);
        checkOutput("t6_data", data_byte, 8'h5A);
        checkOutput("t6_done_count", done_count, 7);
        checkOutput("final_err_count", err_count, 1);

        repeat (20) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
